// File: rtl/por_sequencer.sv
// Power-on reset sequencer: synchronizes por_l, debounces it, then
// releases the I/O-ring reset, the core reset and por_done in order.
module por_sequencer #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int STAGE_DELAY     = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       por_l,
    input  logic       force_por,
    output logic       resetn_io,
    output logic       resetn_core,
    output logic       por_done,
    output logic [2:0] state,
    output logic [7:0] glitch_cnt
);

    typedef enum logic [2:0] {
        S_HOLD       = 3'd0,
        S_DEBOUNCE   = 3'd1,
        S_STAGE_IO   = 3'd2,
        S_STAGE_CORE = 3'd3,
        S_READY      = 3'd4
    } state_t;

    localparam logic [7:0] DB_LAST = 8'(DEBOUNCE_CYCLES - 1);
    localparam logic [7:0] SD_LAST = 8'(STAGE_DELAY - 1);

    logic [SYNC_STAGES-1:0] r_sync;
    state_t                 r_state;
    state_t                 w_next;
    logic [7:0]             r_cnt;
    logic [7:0]             w_cnt_next;
    logic                   w_por_s;
    logic                   w_abort;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], por_l};
        end
    end

    assign w_por_s = r_sync[SYNC_STAGES-1];

    // Priority: force_por, then a low por_s, then counter progress.
    always_comb begin
        w_next  = r_state;
        w_abort = 1'b0;
        if (force_por) begin
            w_next = S_HOLD;
        end else if (!w_por_s) begin
            w_next  = S_HOLD;
            w_abort = (r_state == S_DEBOUNCE);
        end else begin
            unique case (r_state)
                S_HOLD:       w_next = S_DEBOUNCE;
                S_DEBOUNCE:   if (r_cnt == DB_LAST) w_next = S_STAGE_IO;
                S_STAGE_IO:   if (r_cnt == SD_LAST) w_next = S_STAGE_CORE;
                S_STAGE_CORE: if (r_cnt == SD_LAST) w_next = S_READY;
                S_READY:      w_next = S_READY;
                default:      w_next = S_HOLD;
            endcase
        end
    end

    always_comb begin
        w_cnt_next = r_cnt;
        if (w_next != r_state) begin
            w_cnt_next = 8'd0;
        end else if (r_state != S_HOLD && r_state != S_READY
                     && r_cnt != 8'hFF) begin
            w_cnt_next = r_cnt + 8'd1;
        end
    end

    // Outputs decode the next state so they change with the state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_HOLD;
            r_cnt       <= 8'd0;
            resetn_io   <= 1'b0;
            resetn_core <= 1'b0;
            por_done    <= 1'b0;
            glitch_cnt  <= 8'd0;
        end else begin
            r_state     <= w_next;
            r_cnt       <= w_cnt_next;
            resetn_io   <= (w_next == S_STAGE_IO) ||
                           (w_next == S_STAGE_CORE) ||
                           (w_next == S_READY);
            resetn_core <= (w_next == S_STAGE_CORE) ||
                           (w_next == S_READY);
            por_done    <= (w_next == S_READY);
            if (w_abort && glitch_cnt != 8'hFF) begin
                glitch_cnt <= glitch_cnt + 8'd1;
            end
        end
    end

    assign state = r_state;

endmodule

// File: tb/tb_por_sequencer.sv
// Scoreboard bench for por_sequencer: an elapsed-time reference model
// pushes expected outputs per edge, a negedge monitor pops and compares.
module tb_por_sequencer;

    localparam int SYNC = 2;
    localparam int DB   = 16;
    localparam int SD   = 8;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       por_l = 1'b0;
    logic       force_por = 1'b0;
    logic       resetn_io;
    logic       resetn_core;
    logic       por_done;
    logic [2:0] state;
    logic [7:0] glitch_cnt;

    por_sequencer #(
        .SYNC_STAGES(SYNC),
        .DEBOUNCE_CYCLES(DB),
        .STAGE_DELAY(SD)
    ) dut (
        .clk(clk),
        .reset(reset),
        .por_l(por_l),
        .force_por(force_por),
        .resetn_io(resetn_io),
        .resetn_core(resetn_core),
        .por_done(por_done),
        .state(state),
        .glitch_cnt(glitch_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        int   edge_n;
        int   st;
        logic io;
        logic core;
        logic done;
        int   gl;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   failures = 0;

    // Reference model: por_s is por_l delayed SYNC edges; once por_s is
    // seen high the state is a pure function of edges elapsed since then.
    bit ps_q[$];
    bit running = 0;
    int start_edge = 0;
    int gl_m = 0;
    int n = 0;

    function automatic int stage_of(int e);
        if (e < DB) return 1;
        if (e < DB + SD) return 2;
        if (e < DB + 2 * SD) return 3;
        return 4;
    endfunction

    task automatic cmp(string nm, int act, int exp_v);
        checks++;
        if (act != exp_v) begin
            failures++;
            $display("FAIL %s @edge %0d: got %0d, expected %0d",
                     nm, n, act, exp_v);
        end
    endtask

    task automatic model(bit p, bit f, bit r);
        bit   ps;
        exp_t x;
        if (r) begin
            ps_q.delete();
            for (int i = 0; i < SYNC; i++) ps_q.push_back(1'b0);
            running = 0;
            gl_m = 0;
        end else begin
            ps = ps_q.pop_front();
            ps_q.push_back(p);
            if (f) begin
                running = 0;
            end else if (!ps) begin
                if (running && stage_of(n - 1 - start_edge) == 1)
                    gl_m = (gl_m < 255) ? gl_m + 1 : 255;
                running = 0;
            end else if (!running) begin
                running = 1;
                start_edge = n;
            end
        end
        x.edge_n = n;
        x.st   = running ? stage_of(n - start_edge) : 0;
        x.io   = (x.st >= 2);
        x.core = (x.st >= 3);
        x.done = (x.st == 4);
        x.gl   = gl_m;
        sb.push_back(x);
        n++;
    endtask

    task automatic step(bit p, bit f, bit r);
        por_l = p;
        force_por = f;
        reset = r;
        @(posedge clk);
        model(p, f, r);
        #1;
    endtask

    always @(negedge clk) begin
        exp_t x;
        while (sb.size() > 0) begin
            x = sb.pop_front();
            cmp("sb_state", int'(state), x.st);
            cmp("sb_resetn_io", int'(resetn_io), int'(x.io));
            cmp("sb_resetn_core", int'(resetn_core), int'(x.core));
            cmp("sb_por_done", int'(por_done), int'(x.done));
            cmp("sb_glitch_cnt", int'(glitch_cnt), x.gl);
        end
        checks++;
        if ((resetn_core === 1'b1 && resetn_io !== 1'b1) ||
            (por_done === 1'b1 && resetn_core !== 1'b1)) begin
            failures++;
            $display("FAIL monotonic: io=%b core=%b done=%b",
                     resetn_io, resetn_core, por_done);
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int len;
        bit lvl;
        for (int i = 0; i < SYNC; i++) ps_q.push_back(1'b0);

        repeat (3) step(0, 0, 1);
        cmp("rst_state", int'(state), 0);
        cmp("rst_io", int'(resetn_io), 0);
        cmp("rst_glitch", int'(glitch_cnt), 0);
        repeat (2) step(0, 0, 0);

        // nominal rise
        for (int e = 0; e < 40; e++) begin
            step(1, 0, 0);
            cmp("nom_io", int'(resetn_io), int'(e >= 18));
            cmp("nom_core", int'(resetn_core), int'(e >= 26));
            cmp("nom_done", int'(por_done), int'(e >= 34));
        end
        cmp("nom_glitch", int'(glitch_cnt), 0);

        // single-cycle brown-out from READY
        step(0, 0, 0);
        cmp("bo_m_done", int'(por_done), 1);
        step(1, 0, 0);
        cmp("bo_m1_done", int'(por_done), 1);
        step(1, 0, 0);
        cmp("bo_m2_done", int'(por_done), 0);
        cmp("bo_m2_io", int'(resetn_io), 0);
        cmp("bo_m2_state", int'(state), 0);
        cmp("bo_glitch", int'(glitch_cnt), 0);
        repeat (40) step(1, 0, 0);
        cmp("pre_force_done", int'(por_done), 1);

        // force_por from READY
        step(1, 1, 0);
        cmp("frc_io", int'(resetn_io), 0);
        cmp("frc_done", int'(por_done), 0);
        cmp("frc_state", int'(state), 0);
        repeat (40) step(1, 0, 0);
        cmp("frc_glitch", int'(glitch_cnt), 0);
        repeat (3) step(1, 1, 0);
        cmp("frc_held_state", int'(state), 0);

        // debounce aborts
        repeat (2) step(0, 0, 1);
        repeat (3) step(0, 0, 0);
        repeat (3) begin
            repeat (10) step(1, 0, 0);
            repeat (3) step(0, 0, 0);
        end
        for (int e = 0; e < 20; e++) begin
            step(1, 0, 0);
            if (e == 17) cmp("ab_io_pre", int'(resetn_io), 0);
            if (e == 18) cmp("ab_io_rise", int'(resetn_io), 1);
        end
        cmp("ab_glitch", int'(glitch_cnt), 3);

        // saturation
        repeat (260) begin
            repeat (4) step(1, 0, 0);
            repeat (3) step(0, 0, 0);
        end
        cmp("sat_glitch", int'(glitch_cnt), 255);

        // reset mid-sequence in STAGE_CORE
        step(0, 0, 1);
        repeat (28) step(1, 0, 0);
        cmp("mid_state", int'(state), 3);
        step(1, 0, 1);
        cmp("mid_rst_state", int'(state), 0);
        cmp("mid_rst_io", int'(resetn_io), 0);
        cmp("mid_rst_core", int'(resetn_core), 0);
        cmp("mid_rst_glitch", int'(glitch_cnt), 0);
        repeat (5) step(1, 0, 0);

        // random segments
        lvl = 1'b0;
        for (int s = 0; s < 150; s++) begin
            lvl = ~lvl;
            len = $urandom_range(1, 60);
            for (int c = 0; c < len; c++) begin
                step(lvl, ($urandom_range(0, 63) == 0),
                     ($urandom_range(0, 499) == 0));
            end
        end

        #10;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
